c3lib_ctn_ckgate_seq: RTL and testbench
=======================================

// Module: c3lib_ctn_ckgate_seq
// PURPOSE
//  Staggered enable/disable sequencer for gated clock-tree (CTN) branches.
//  - Each gate_en bit drives one branch clock gate feeding its CTN buffer chain.
//  - Walks gate_en toward the requested mask one bit per STAGGER_CYC cycles,
//    which bounds di/dt on the clock network.
//  - Sits in the clock-control domain next to the CTN buffers.
//  - Reports busy and a one-cycle done pulse on convergence.
// PARAMETERS
//  NUM_BR       4     number of gated branches (>=1)
//  STAGGER_CYC  3     cycles between successive toggles (>=1)
//  RST_EN       '0    NUM_BR-bit gate_en value applied during reset
// PORTS
//  clk      in   1       sequencer clock (free-running, ungated)
//  rst_n    in   1       asynchronous active-low reset
//  en_req   in   NUM_BR  requested enable mask, level, synchronous to clk
//  hold     in   1       freeze: FSM, counter and gate_en held while 1
//  gate_en  out  NUM_BR  branch clock-gate enables (flopped)
//  busy     out  1       1 while state==WAIT (decoded from state flop only)
//  done     out  1       1-cycle pulse when sequence converges
// BEHAVIOUR
//  - Reset (rst_n=0, async): gate_en=RST_EN, state=IDLE, cnt=0, done=0, busy=0.
//  - Combinational terms:
//    - diff = en_req ^ gate_en
//    - pick = lowest set bit of diff (index 0 wins)
//  - IDLE, hold=0, diff!=0: at the edge, toggle gate_en[pick], cnt<=STAGGER_CYC-1,
//    go to WAIT.
//  - IDLE, diff==0: stay in IDLE, no output change.
//  - WAIT, hold=0, cnt!=0: cnt<=cnt-1.
//  - WAIT, hold=0, cnt==0:
//    - diff!=0: toggle gate_en[pick], reload cnt, stay in WAIT.
//    - diff==0: go to IDLE and assert done for exactly one cycle.
//  - Spacing: consecutive toggles are exactly STAGGER_CYC edges apart. done follows
//    the last toggle by STAGGER_CYC edges.
//  - Only one gate_en bit changes per edge, ever. No gate_en change in IDLE->IDLE.
//  - en_req is sampled only at decision edges:
//    - changes during WAIT take effect at the next decision edge;
//    - a bit already toggled may toggle back (no lock-out).
//  - hold=1: all state is frozen and done=0. Releasing hold resumes exactly where it
//    stopped, with no extra or lost counts.
//  - Reset mid-WAIT: immediate return to reset values. After release, if
//    en_req!=RST_EN, a fresh sequence starts from IDLE.
//  - cnt width = $clog2(STAGGER_CYC+1). No wrap: cnt never decrements below 0.
//  - All outputs are flop-driven or single-flop decodes. No comb path from inputs to
//    outputs.
// STRUCTURE
//  - Package c3lib_ctn_pkg:
//    - typedef enum logic {CTN_SEQ_IDLE, CTN_SEQ_WAIT} ctn_seq_state_t
//    - localparam defaults for NUM_BR and STAGGER_CYC
//  - Sub-module c3lib_ctn_lsb_pick (param W): diff[W-1:0] -> one-hot pick plus valid.
//    Purely combinational.
//  - Top level holds the state flop, cnt, gate_en and done registers.
// TESTING (NUM_BR=4, STAGGER_CYC=3, RST_EN=0 unless noted; cN = Nth edge after release)
//  1. en_req=4'hF from reset -> gate_en 0001@c1, 0011@c4, 0111@c7, 1111@c10;
//     busy c1..c12; done=1 only after c13.
//  2. From converged 1111, en_req=0 -> 1110, 1100, 1000, 0000 at 3-edge spacing;
//     single done pulse.
//  3. en_req=F, then en_req=0001 after c5 -> 0011@c4, 0001@c7 (bit1 off), done after
//     c10; never 0111.
//  4. hold=1 for 5 cycles starting after c2 -> every later toggle and done shift by
//     exactly 5 edges; gate_en stable during hold.
//  5. rst_n low asynchronously mid-WAIT (no clk edge) -> gate_en=RST_EN, busy=0,
//     done=0 at once; after release, restart as in test 1.
//  6. STAGGER_CYC=1, en_req 0000->1010 -> 0010@c1, 1010@c2, done after c3.
//  - Checker on every test: popcount(gate_en ^ $past(gate_en)) <= 1 on every cycle.

Source files
------------

// File: rtl/c3lib_ctn_pkg.sv
// Shared types and default parameters for the CTN clock-gate sequencer.
package c3lib_ctn_pkg;

  typedef enum logic {
    CTN_SEQ_IDLE,
    CTN_SEQ_WAIT
  } ctn_seq_state_t;

  localparam int CTN_NUM_BR_DEF      = 4;
  localparam int CTN_STAGGER_CYC_DEF = 3;

endpackage : c3lib_ctn_pkg

// File: rtl/c3lib_ctn_lsb_pick.sv
// Lowest-set-bit picker: one-hot of the least significant set bit of diff.
module c3lib_ctn_lsb_pick #(
  parameter int W = 4
) (
  input  logic [W-1:0] diff,
  output logic [W-1:0] pick,
  output logic         valid
);

  // Two's-complement trick isolates the lowest set bit, so index 0 wins.
  assign pick  = diff & (~diff + W'(1));
  assign valid = |diff;

endmodule : c3lib_ctn_lsb_pick

// File: rtl/c3lib_ctn_ckgate_seq.sv
// Staggered enable/disable sequencer for gated clock-tree branches.
// gate_en walks toward en_req one bit at a time, with STAGGER_CYC edges
// between toggles, to bound di/dt on the clock network.
module c3lib_ctn_ckgate_seq
  import c3lib_ctn_pkg::*;
#(
  parameter int                NUM_BR      = CTN_NUM_BR_DEF,
  parameter int                STAGGER_CYC = CTN_STAGGER_CYC_DEF,
  parameter logic [NUM_BR-1:0] RST_EN      = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_BR-1:0] en_req,
  input  logic              hold,
  output logic [NUM_BR-1:0] gate_en,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W      = $clog2(STAGGER_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STAGGER_CYC - 1);

  ctn_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_BR-1:0] gate_en_q, gate_en_d;
  logic              done_q, done_d;

  logic [NUM_BR-1:0] diff;
  logic [NUM_BR-1:0] pick;
  logic              pick_valid;

  assign diff = en_req ^ gate_en_q;

  c3lib_ctn_lsb_pick #(
    .W (NUM_BR)
  ) u_lsb_pick (
    .diff  (diff),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Next-state: toggle one branch at each decision edge, count the gap between.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    gate_en_d = gate_en_q;
    done_d    = 1'b0;
    if (!hold) begin
      unique case (state_q)
        CTN_SEQ_IDLE: begin
          if (pick_valid) begin
            gate_en_d = gate_en_q ^ pick;
            cnt_d     = CNT_RELOAD;
            state_d   = CTN_SEQ_WAIT;
          end
        end
        CTN_SEQ_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (pick_valid) begin
            gate_en_d = gate_en_q ^ pick;
            cnt_d     = CNT_RELOAD;
          end else begin
            state_d = CTN_SEQ_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = CTN_SEQ_IDLE;
      endcase
    end
  end

  // State, counter, gate enables and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CTN_SEQ_IDLE;
      cnt_q     <= '0;
      gate_en_q <= RST_EN;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so all flops update from the same pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gate_en_q <= gate_en_d;
      done_q    <= done_d;
    end
  end

  assign gate_en = gate_en_q;
  assign busy    = (state_q == CTN_SEQ_WAIT);
  assign done    = done_q;

endmodule : c3lib_ctn_ckgate_seq

// File: tb/tb_c3lib_ctn_ckgate_seq.sv
// Scoreboard bench: stimulus queues expected gate_en/done events with their
// cycle stamps; a monitor pops one whenever gate_en changes or done is high.
module tb_c3lib_ctn_ckgate_seq;

  typedef struct {
    int         cyc;
    logic [3:0] ge;
    logic       busy;
    logic       done;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en_req = 4'hF;
  logic       hold = 1'b0;
  logic [3:0] gate_en;
  logic       busy, done;

  logic [3:0] en_req1 = 4'h0;
  logic       hold1 = 1'b0;
  logic [3:0] gate_en1;
  logic       busy1, done1;

  int  cyc = 0;
  int  base = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t exp_q[$];
  logic [3:0] prev_ge = 4'h0;

  c3lib_ctn_ckgate_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_req  (en_req),
    .hold    (hold),
    .gate_en (gate_en),
    .busy    (busy),
    .done    (done)
  );

  c3lib_ctn_ckgate_seq #(.STAGGER_CYC(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_req  (en_req1),
    .hold    (hold1),
    .gate_en (gate_en1),
    .busy    (busy1),
    .done    (done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc - base);
  endtask

  task automatic push(input int c, input logic [3:0] ge, input logic b, input logic d);
    ev_t e;
    e.cyc = base + c; e.ge = ge; e.busy = b; e.done = d;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for every queued event to be consumed, then confirm quiet.
  task automatic drain(input string name, input logic [3:0] final_ge);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_final_ge"}, {28'h0, gate_en}, {28'h0, final_ge});
    check({name, "_final_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // Monitor: compare each observed output event against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ge = gate_en;
    end else begin
      check("single_bit_step", {31'h0, ($countones(gate_en ^ prev_ge) <= 1)}, 32'h1);
      if (gate_en !== prev_ge || done !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event_ge", {28'h0, gate_en}, {28'h0, prev_ge});
          check("unexpected_event_done", {31'h0, done}, 32'h0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("ev_cycle", cyc - base, e.cyc - base);
          check("ev_gate_en", {28'h0, gate_en}, {28'h0, e.ge});
          check("ev_busy", {31'h0, busy}, {31'h0, e.busy});
          check("ev_done", {31'h0, done}, {31'h0, e.done});
        end
      end
      prev_ge = gate_en;
    end
  end

  task automatic push_up_from_zero();
    push(1, 4'b0001, 1, 0); push(4, 4'b0011, 1, 0);
    push(7, 4'b0111, 1, 0); push(10, 4'b1111, 1, 0);
    push(13, 4'b1111, 0, 1);
  endtask

  task automatic go_down_to_zero(input string name);
    @(negedge clk); base = cyc; en_req = 4'h0;
    push(1, 4'b1110, 1, 0); push(4, 4'b1100, 1, 0);
    push(7, 4'b1000, 1, 0); push(10, 4'b0000, 1, 0);
    push(13, 4'b0000, 0, 1);
    drain(name, 4'h0);
  endtask

  initial begin
    // Reset values.
    #12;
    check("rst_gate_en", {28'h0, gate_en}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);

    // Test 1: ramp up from reset.
    @(negedge clk); base = cyc; rst_n = 1'b1;
    push_up_from_zero();
    repeat (12) @(negedge clk);
    check("t1_busy_c12", {31'h0, busy}, 32'h1);
    drain("t1", 4'hF);

    // Test 2: ramp down.
    go_down_to_zero("t2");

    // Test 4: hold for 5 edges after c2 shifts everything later by 5.
    @(negedge clk); base = cyc; en_req = 4'hF;
    push(1, 4'b0001, 1, 0); push(9, 4'b0011, 1, 0);
    push(12, 4'b0111, 1, 0); push(15, 4'b1111, 1, 0);
    push(18, 4'b1111, 0, 1);
    repeat (2) @(negedge clk); hold = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_busy_in_hold", {31'h0, busy}, 32'h1);
    check("t4_ge_in_hold", {28'h0, gate_en}, 32'h1);
    hold = 1'b0;
    drain("t4", 4'hF);
    go_down_to_zero("t4_cleanup");

    // Test 3: request shrinks mid-sequence; bit 1 turns back off.
    @(negedge clk); base = cyc; en_req = 4'hF;
    push(1, 4'b0001, 1, 0); push(4, 4'b0011, 1, 0);
    push(7, 4'b0001, 1, 0); push(10, 4'b0001, 0, 1);
    repeat (5) @(negedge clk); en_req = 4'b0001;
    drain("t3", 4'b0001);

    // Test 5: async reset mid-WAIT, then a fresh ramp.
    @(negedge clk); base = cyc; en_req = 4'hF;
    push(1, 4'b0011, 1, 0); push(4, 4'b0111, 1, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_gate_en", {28'h0, gate_en}, 32'h0);
    check("t5_rst_busy", {31'h0, busy}, 32'h0);
    check("t5_rst_done", {31'h0, done}, 32'h0);
    check("t5_events_consumed", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    base = cyc; rst_n = 1'b1;
    push_up_from_zero();
    drain("t5", 4'hF);

    // Test 6: STAGGER_CYC=1 instance.
    @(negedge clk); base = cyc; en_req1 = 4'b1010;
    @(negedge clk);
    check("t6_c1_ge", {28'h0, gate_en1}, 32'b0010);
    check("t6_c1_busy", {31'h0, busy1}, 32'h1);
    check("t6_c1_done", {31'h0, done1}, 32'h0);
    @(negedge clk);
    check("t6_c2_ge", {28'h0, gate_en1}, 32'b1010);
    check("t6_c2_done", {31'h0, done1}, 32'h0);
    @(negedge clk);
    check("t6_c3_done", {31'h0, done1}, 32'h1);
    check("t6_c3_busy", {31'h0, busy1}, 32'h0);
    check("t6_c3_ge", {28'h0, gate_en1}, 32'b1010);
    @(negedge clk);
    check("t6_c4_done", {31'h0, done1}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_c3lib_ctn_ckgate_seq
